// File: rtl/lsu_stage_if.sv
// lsu_stage_if: data-memory request/response bus between the LSU and data memory.
// Latency: none, wires only.
// Backpressure: the memory withholds dmem_gnt_i / dmem_rvalid_i to stall the LSU.
// Ports: master = LSU side (drives req/we/addr/wdata/be, receives gnt/rvalid/rdata);
//   slave = memory side (mirror image).
interface lsu_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic [31:0]       dmem_wdata_o;
    logic [3:0]        dmem_be_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [31:0]       dmem_rdata_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
    );
endinterface

// File: rtl/lsu_stage.sv
// lsu_stage: MEM-stage load/store unit driving a req/gnt/rvalid data-memory bus.
// Latency: store stalls 2 cycles, load 3 cycles minimum (gnt and rvalid immediate).
// Backpressure: stall_o freezes upstream while the bus withholds gnt or rvalid.
// Ports: clk, rst (synchronous, active-high); pipeline inputs valid_i, mem_read_i,
//   mem_write_i, funct3_i, alu_out_i, wdata_i; outputs alu_out_o, mem_rdata_o,
//   stall_o, misalign_o; dmem (lsu_stage_if.master) data-memory bus.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of issuing them.
module lsu_stage #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] alu_out_o,
    output logic [31:0] mem_rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    lsu_stage_if.master dmem
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              access, is_store;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [31:0]       rdata_q;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;

    // A read and a write flagged together is treated as a load.
    assign access   = valid_i & (mem_read_i | mem_write_i);
    assign is_store = mem_write_i & ~mem_read_i;

    assign alu_out_o   = alu_out_i;
    assign mem_rdata_o = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned, mis_q;

    always_comb begin
        misaligned = 1'b0;
        if (funct3_i[1:0] == 2'b01)
            misaligned = alu_out_i[0];
        else if (funct3_i == 3'b010)
            misaligned = (alu_out_i[1:0] != 2'b00);
    end

    // Only flagged during the DONE cycle of a trapped access.
    assign misalign_o = (state_q == S_DONE) & mis_q;
`else
    assign misalign_o = 1'b0;
`endif

    // Store lane steering; loads always fetch the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
        if (is_store) begin
            case (funct3_i)
                3'b000: begin
                    be_d    = 4'b0001 << alu_out_i[1:0];
                    wdata_d = {4{wdata_i[7:0]}};
                end
                3'b001: begin
                    be_d    = alu_out_i[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata_i[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Load extraction from the latched byte offset and size.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = dmem.dmem_rdata_i[7:0];
            2'd1:    byte_sel = dmem.dmem_rdata_i[15:8];
            2'd2:    byte_sel = dmem.dmem_rdata_i[23:16];
            default: byte_sel = dmem.dmem_rdata_i[31:24];
        endcase
        half_sel = addr_q[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'b0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = dmem.dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    stall_o = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    state_d = misaligned ? S_DONE : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                if (dmem.dmem_gnt_i)
                    state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                stall_o = 1'b1;
                if (dmem.dmem_rvalid_i)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'b0;
            wdata_q  <= 32'b0;
            funct3_q <= 3'b0;
            rdata_q  <= 32'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && access) begin
                addr_q   <= alu_out_i[ADDR_W-1:0];
                we_q     <= is_store;
                be_q     <= be_d;
                wdata_q  <= wdata_d;
                funct3_q <= funct3_i;
`ifdef LSU_MISALIGN_TRAP_EN
                mis_q    <= misaligned;
`endif
            end
            if (state_q == S_WAIT && dmem.dmem_rvalid_i)
                rdata_q <= load_data;
        end
    end

    // Bus fields come from registers so they stay stable for the whole REQ phase.
    assign dmem.dmem_req_o   = (state_q == S_REQ);
    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata_o = wdata_q;
    assign dmem.dmem_be_o    = be_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: directed self-checking bench for lsu_stage.
// Latency: inputs driven on falling edges, outputs sampled 1 time unit later.
// Backpressure: the bench plays the memory, driving gnt/rvalid by hand.
module tb_lsu_stage;
    logic        clk;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] alu_out_i, wdata_i;
    logic [31:0] alu_out_o, mem_rdata_o;
    logic        stall_o, misalign_o;
    int          passed = 0;
    int          total  = 0;

    lsu_stage_if #(.ADDR_W(32)) dmem ();

    lsu_stage #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .alu_out_i   (alu_out_i),
        .wdata_i     (wdata_i),
        .alu_out_o   (alu_out_o),
        .mem_rdata_o (mem_rdata_o),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .dmem        (dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'b0; alu_out_i = 32'b0; wdata_i = 32'b0;
        dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else passed++;
        total++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", dmem.dmem_req_o); else passed++;
        total++; if (misalign_o !== 1'b0) $display("FAIL rst_misalign: got %b want 0", misalign_o); else passed++;
        total++; if (mem_rdata_o !== 32'h0) $display("FAIL rst_rdata: got %h want 0", mem_rdata_o); else passed++;
        total++; if (dmem.dmem_be_o !== 4'h0) $display("FAIL rst_be: got %b want 0000", dmem.dmem_be_o); else passed++;
    endtask

    task automatic test_non_access();
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; alu_out_i = 32'hDEADBEEF;
        #1;
        total++; if (alu_out_o !== 32'hDEADBEEF) $display("FAIL alu_pass: got %h want deadbeef", alu_out_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL nonacc_stall: got %b want 0", stall_o); else passed++;
        @(negedge clk); #1;
        total++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL nonacc_req: got %b want 0", dmem.dmem_req_o); else passed++;
        valid_i = 1'b0;
    endtask

    task automatic test_store();
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = 3'b000;
        alu_out_i = 32'h103; wdata_i = 32'h000000A5;
        dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b0;
        #1;
        total++; if (stall_o !== 1'b1) $display("FAIL sb_stall_idle: got %b want 1", stall_o); else passed++;
        total++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL sb_req_idle: got %b want 0", dmem.dmem_req_o); else passed++;
        @(negedge clk); #1;
        total++; if (dmem.dmem_req_o !== 1'b1) $display("FAIL sb_req: got %b want 1", dmem.dmem_req_o); else passed++;
        total++; if (dmem.dmem_addr_o !== 32'h100) $display("FAIL sb_addr: got %h want 00000100", dmem.dmem_addr_o); else passed++;
        total++; if (dmem.dmem_be_o !== 4'b1000) $display("FAIL sb_be: got %b want 1000", dmem.dmem_be_o); else passed++;
        total++; if (dmem.dmem_wdata_o !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", dmem.dmem_wdata_o); else passed++;
        total++; if (dmem.dmem_we_o !== 1'b1) $display("FAIL sb_we: got %b want 1", dmem.dmem_we_o); else passed++;
        total++; if (stall_o !== 1'b1) $display("FAIL sb_stall_req: got %b want 1", stall_o); else passed++;
        @(negedge clk); #1;
        total++; if (stall_o !== 1'b0) $display("FAIL sb_stall_done: got %b want 0", stall_o); else passed++;
        total++; if (dmem.dmem_req_o !== 1'b0) $display("FAIL sb_req_done: got %b want 0", dmem.dmem_req_o); else passed++;
        // Next instruction: SH to the upper halfword.
        funct3_i = 3'b001; alu_out_i = 32'h102; wdata_i = 32'h1234BEEF;
        @(negedge clk); #1;
        total++; if (stall_o !== 1'b1) $display("FAIL sh_stall_idle: got %b want 1", stall_o); else passed++;
        @(negedge clk); #1;
        total++; if (dmem.dmem_be_o !== 4'b1100) $display("FAIL sh_be: got %b want 1100", dmem.dmem_be_o); else passed++;
        total++; if (dmem.dmem_wdata_o !== 32'hBEEFBEEF) $display("FAIL sh_wdata: got %h want beefbeef", dmem.dmem_wdata_o); else passed++;
        total++; if (dmem.dmem_addr_o !== 32'h100) $display("FAIL sh_addr: got %h want 00000100", dmem.dmem_addr_o); else passed++;
        @(negedge clk);
        valid_i = 1'b0; mem_write_i = 1'b0;
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp, input string name);
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = f3; alu_out_i = addr;
        dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b0;
        #1;
        total++; if (stall_o !== 1'b1) $display("FAIL %s_stall_idle: got %b want 1", name, stall_o); else passed++;
        @(negedge clk); #1;
        total++; if (dmem.dmem_req_o !== 1'b1 || dmem.dmem_we_o !== 1'b0 || dmem.dmem_be_o !== 4'b1111)
            $display("FAIL %s_req: got req=%b we=%b be=%b want 1 0 1111", name, dmem.dmem_req_o, dmem.dmem_we_o, dmem.dmem_be_o);
        else passed++;
        dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = rdata;
        @(negedge clk); #1;
        total++; if (stall_o !== 1'b1 || dmem.dmem_req_o !== 1'b0)
            $display("FAIL %s_wait: got stall=%b req=%b want 1 0", name, stall_o, dmem.dmem_req_o);
        else passed++;
        @(negedge clk); #1;
        total++; if (stall_o !== 1'b0) $display("FAIL %s_stall_done: got %b want 0", name, stall_o); else passed++;
        total++; if (mem_rdata_o !== exp) $display("FAIL %s_rdata: got %h want %h", name, mem_rdata_o, exp); else passed++;
        valid_i = 1'b0; mem_read_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'h0;
        @(negedge clk); #1;
        total++; if (mem_rdata_o !== exp) $display("FAIL %s_hold: got %h want %h", name, mem_rdata_o, exp); else passed++;
    endtask

    task automatic test_gnt_delay();
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; alu_out_i = 32'h200;
        dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            total++; if (dmem.dmem_req_o !== 1'b1 || dmem.dmem_addr_o !== 32'h200 || stall_o !== 1'b1)
                $display("FAIL lw_hold_%0d: got req=%b addr=%h stall=%b want 1 00000200 1", k, dmem.dmem_req_o, dmem.dmem_addr_o, stall_o);
            else passed++;
            if (k == 1) begin dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'hBAD0BAD0; end
            if (k == 2) begin
                dmem.dmem_rvalid_i = 1'b0;
                total++; if (mem_rdata_o !== 32'h000012F4) $display("FAIL lw_spurious: got %h want 000012f4", mem_rdata_o); else passed++;
            end
            if (k == 3) dmem.dmem_gnt_i = 1'b1;
        end
        @(negedge clk); #1;
        total++; if (dmem.dmem_req_o !== 1'b0 || stall_o !== 1'b1)
            $display("FAIL lw_wait: got req=%b stall=%b want 0 1", dmem.dmem_req_o, stall_o);
        else passed++;
        dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h11223344;
        @(negedge clk); #1;
        total++; if (mem_rdata_o !== 32'h11223344) $display("FAIL lw_rdata: got %h want 11223344", mem_rdata_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL lw_done_stall: got %b want 0", stall_o); else passed++;
        valid_i = 1'b0; mem_read_i = 1'b0; dmem.dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_misalign();
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; alu_out_i = 32'h101;
        dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h89ABCDEF;
        #1;
        total++; if (stall_o !== 1'b1 || misalign_o !== 1'b0)
            $display("FAIL mis_idle: got stall=%b misalign=%b want 1 0", stall_o, misalign_o);
        else passed++;
        @(negedge clk); #1;
`ifdef LSU_MISALIGN_TRAP_EN
        total++; if (misalign_o !== 1'b1 || stall_o !== 1'b0 || dmem.dmem_req_o !== 1'b0)
            $display("FAIL mis_trap: got misalign=%b stall=%b req=%b want 1 0 0", misalign_o, stall_o, dmem.dmem_req_o);
        else passed++;
        total++; if (mem_rdata_o !== 32'h11223344) $display("FAIL mis_rdata: got %h want 11223344", mem_rdata_o); else passed++;
        valid_i = 1'b0; mem_read_i = 1'b0;
        @(negedge clk); #1;
        total++; if (misalign_o !== 1'b0 || dmem.dmem_req_o !== 1'b0)
            $display("FAIL mis_after: got misalign=%b req=%b want 0 0", misalign_o, dmem.dmem_req_o);
        else passed++;
`else
        total++; if (dmem.dmem_req_o !== 1'b1 || dmem.dmem_addr_o !== 32'h100 || misalign_o !== 1'b0)
            $display("FAIL mis_req: got req=%b addr=%h misalign=%b want 1 00000100 0", dmem.dmem_req_o, dmem.dmem_addr_o, misalign_o);
        else passed++;
        @(negedge clk); @(negedge clk); #1;
        total++; if (mem_rdata_o !== 32'h89ABCDEF || stall_o !== 1'b0)
            $display("FAIL mis_rdata: got rdata=%h stall=%b want 89abcdef 0", mem_rdata_o, stall_o);
        else passed++;
        valid_i = 1'b0; mem_read_i = 1'b0;
`endif
        dmem.dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; alu_out_i = 32'h300;
        dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        total++; if (stall_o !== 1'b1 || mem_rdata_o === 32'h0)
            $display("FAIL rstmid_pre: got stall=%b rdata=%h want 1 nonzero", stall_o, mem_rdata_o);
        else passed++;
        rst = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0 || dmem.dmem_req_o !== 1'b0 || mem_rdata_o !== 32'h0)
            $display("FAIL rstmid_post: got stall=%b req=%b rdata=%h want 0 0 0", stall_o, dmem.dmem_req_o, mem_rdata_o);
        else passed++;
        dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'hCAFEF00D;
        @(negedge clk); #1;
        total++; if (mem_rdata_o !== 32'h0 || stall_o !== 1'b0 || dmem.dmem_req_o !== 1'b0)
            $display("FAIL rstmid_late: got rdata=%h stall=%b req=%b want 0 0 0", mem_rdata_o, stall_o, dmem.dmem_req_o);
        else passed++;
        dmem.dmem_rvalid_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int idx = 0, cyc = 0, reqs = 0, store_reqs = 0, adv = 0;
        @(negedge clk);
        valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b1; funct3_i = 3'b010;
        alu_out_i = 32'h400; wdata_i = 32'h55667788;
        dmem.dmem_gnt_i = 1'b1; dmem.dmem_rvalid_i = 1'b1; dmem.dmem_rdata_i = 32'h0A0B0C0D;
        while (idx < 2 && cyc < 20) begin
            #1;
            if (dmem.dmem_req_o) begin
                reqs++;
                if (dmem.dmem_we_o) store_reqs++;
            end
            cyc++;
            if (valid_i && !stall_o) begin
                adv++;
                idx++;
            end
            @(negedge clk);
            if (idx == 1) begin
                mem_read_i = 1'b1; mem_write_i = 1'b0; alu_out_i = 32'h404;
            end else if (idx == 2) begin
                valid_i = 1'b0; mem_read_i = 1'b0;
            end
        end
        total++; if (reqs !== 2) $display("FAIL b2b_reqs: got %0d want 2", reqs); else passed++;
        total++; if (store_reqs !== 1) $display("FAIL b2b_store_reqs: got %0d want 1", store_reqs); else passed++;
        total++; if (adv !== 2) $display("FAIL b2b_advance: got %0d want 2", adv); else passed++;
        total++; if (cyc !== 7) $display("FAIL b2b_cycles: got %0d want 7", cyc); else passed++;
        total++; if (mem_rdata_o !== 32'h0A0B0C0D) $display("FAIL b2b_rdata: got %h want 0a0b0c0d", mem_rdata_o); else passed++;
    endtask

    initial begin
        test_reset();
        test_non_access();
        test_store();
        test_load(3'b000, 32'h102, 32'h12F45678, 32'hFFFFFFF4, "lb");
        test_load(3'b100, 32'h102, 32'h12F45678, 32'h000000F4, "lbu");
        test_load(3'b101, 32'h100, 32'h1234ABCD, 32'h0000ABCD, "lhu");
        test_load(3'b001, 32'h102, 32'h12F45678, 32'h000012F4, "lh");
        test_gnt_delay();
        test_misalign();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, width of dmem_addr_o (low ADDR_W bits of the computed address).
REQ-002 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have: valid_i  in  1  instruction present in MEM stage.
REQ-005 SHALL have: mem_read_i / mem_write_i  in  1 each  load / store request.
REQ-006 SHALL have: funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have: alu_out_i  in  32  effective address / ALU result; wdata_i  in  32  store data (rs2).
REQ-008 SHALL have: alu_out_o  out  32  and mem_rdata_o  out  32, both feeding the MEM/WB register.
REQ-009 SHALL have: stall_o  out  1  freezes upstream pipeline registers; misalign_o  out  1  misaligned-access flag.
REQ-010 SHALL have data-memory bus: dmem_req_o, dmem_we_o  out 1; dmem_addr_o  out ADDR_W; dmem_wdata_o  out 32; dmem_be_o  out 4; dmem_gnt_i, dmem_rvalid_i  in 1; dmem_rdata_i  in 32.

Function
REQ-011 SHALL define an access as valid_i & (mem_read_i | mem_write_i); when both are set, read wins.
REQ-012 SHALL drive alu_out_o = alu_out_i combinationally, with no stall for non-access instructions.
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE.
- IDLE: on an access, latch address, we, be, wdata; go to REQ.
- REQ: assert dmem_req_o and hold all bus outputs stable until dmem_gnt_i. Gnt on a store goes to DONE; gnt on a load goes to WAIT.
- WAIT: on dmem_rvalid_i, capture the extracted data and go to DONE.
- DONE: unconditionally go to IDLE.
REQ-014 SHALL assert stall_o combinationally in IDLE when an access is present, and throughout REQ and WAIT; stall_o SHALL be 0 in DONE so upstream advances exactly once.
REQ-015 SHALL drive dmem_addr_o word-aligned ({addr[ADDR_W-1:2],00}) and dmem_we_o = store.
REQ-016 SHALL generate store lanes as follows.
- SB: be = 0001<<addr[1:0], with the byte replicated x4.
- SH: be = 0011<<(2*addr[1]), with the halfword replicated x2.
- SW and funct3 011/110/111: be = 1111.
REQ-017 SHALL drive dmem_be_o = 1111 for loads, and extract the addressed byte/halfword, sign-extending for B/H and zero-extending for BU/HU.
REQ-018 SHALL hold mem_rdata_o in a register updated only on the WAIT capture; the value SHALL be stable in DONE.
REQ-019 SHALL ignore dmem_rvalid_i outside WAIT and dmem_gnt_i outside REQ.
REQ-020 SHALL have minimum latency: store stall 2 cycles with gnt in the first REQ cycle; load stall 3 cycles with gnt in the first REQ cycle and rvalid on the next cycle.
REQ-021 SHALL define misaligned as H/HU with addr[0]=1, or W with addr[1:0]!=00.

Reset
REQ-022 SHALL, on rst at a clock edge, enter IDLE and clear all latched state and mem_rdata_o to 0.
REQ-023 SHALL deassert dmem_req_o, stall_o and misalign_o from the cycle after the reset edge, including when reset occurs mid-transaction.
REQ-024 SHALL ignore responses arriving after reset.

Configuration
REQ-025 SHALL support macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned access issues no bus request and goes IDLE->DONE, with stall_o=1 for one cycle and misalign_o=1 for the DONE cycle only; mem_rdata_o is unchanged.
- Undefined: misalign_o is tied 0, offending low address bits are ignored (H uses addr[1], W uses the whole word), and the access proceeds normally.

Verification
REQ-026 SB addr 0x103, wdata 0x000000A5 -> dmem_addr 0x100, be 1000, wdata 0xA5A5A5A5, stall 2 cycles.
REQ-027 LB addr 0x102, rdata 0x12F45678 -> mem_rdata_o 0xFFFFFFF4; LBU -> 0x000000F4; LH -> 0x000012F4.
REQ-028 LW with gnt delayed 3 cycles -> req/addr held stable for 4 REQ cycles, and a spurious rvalid during REQ is ignored.
REQ-029 LW addr 0x101 -> with macro: misalign_o=1 for one cycle and no dmem_req_o; without macro: request to 0x100.
REQ-030 rst asserted in WAIT -> IDLE next cycle, mem_rdata_o=0, stall_o=0, and a late rvalid is ignored.
REQ-031 Back-to-back SW then LW, with gnt and rvalid immediate -> exactly one request each, and the pipeline advances once per DONE.
